// File: rtl/led_p2s_pkg.sv
// Shared types and default constants for the LED parallel-to-serial sequencer.
package led_p2s_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_DIV     = 4;
  localparam int DEF_REFRESH = 50000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

endpackage

// File: rtl/led_p2s_clkgen.sv
// Divided shift-clock generator with rise/fall tick strobes.
module led_p2s_clkgen
  import led_p2s_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sr_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          tc;

  assign tc        = en && (div_cnt == CW'(DIV - 1));
  assign rise_tick = tc && !sr_clk;
  assign fall_tick = tc && sr_clk;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
      sr_clk  <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sr_clk  <= ~sr_clk;
    end else if (en) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_p2s_ctrl.sv
// LED shift-stage sequencer: handshake, load, shift, latch.
// Optional auto-refresh timer: define LED_P2S_AUTOREFRESH_EN.
module led_p2s_ctrl
  import led_p2s_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int NBITS   = WORD_W,
  parameter int REFRESH = DEF_REFRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              sr_clk,
  output logic [WORD_W-1:0] sr_par,
  output logic              sr_load,
  output logic              led_clrn,
  output logic              led_pen,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  state_t        state, state_d;
  logic [BW-1:0] bit_cnt;
  logic          rise_tick, fall_tick;
  logic          stage_loaded;
  logic          hs, refresh_hit, capture, last_bit;

  led_p2s_clkgen #(.DIV(DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .en        (state != IDLE),
    .clr       (state == IDLE),
    .sr_clk    (sr_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign data_ready = (state == IDLE) && led_clrn;
  assign busy       = (state != IDLE);
  assign hs         = data_valid && data_ready;
  assign last_bit   = (bit_cnt == BW'(NBITS - 1));

`ifdef LED_P2S_AUTOREFRESH_EN
  localparam int TW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || state_d != IDLE) begin
      idle_cnt <= '0;
    end else if (data_ready) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign refresh_hit = data_ready && (idle_cnt == TW'(REFRESH - 1));
`else
  // No timer: a frame never starts on its own.
  assign refresh_hit = (REFRESH < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_d = LOAD;
          capture = 1'b1;
        end else if (refresh_hit) begin
          state_d = LOAD;
        end
      end
      LOAD:    if (fall_tick && stage_loaded) state_d = SHIFT;
      SHIFT:   if (fall_tick && last_bit)     state_d = LATCH;
      LATCH:   if (fall_tick)                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs follow state_d, so they move only on fall ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_par       <= '0;
      sr_load      <= 1'b0;
      led_pen      <= 1'b0;
      frame_done   <= 1'b0;
      led_clrn     <= 1'b0;
      bit_cnt      <= '0;
      stage_loaded <= 1'b0;
    end else begin
      led_clrn   <= 1'b1;
      sr_load    <= (state_d == LOAD);
      led_pen    <= (state_d == LATCH);
      frame_done <= (state == LATCH) && (state_d == IDLE);
      if (capture) sr_par <= data_in;
      if (state != SHIFT)  bit_cnt <= '0;
      else if (fall_tick)  bit_cnt <= bit_cnt + 1'b1;
      if (state != LOAD)   stage_loaded <= 1'b0;
      else if (rise_tick)  stage_loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_p2s_ctrl.sv
// Self-checking bench for led_p2s_ctrl (DIV=4 and DIV=1 instances).
module tb_led_p2s_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        valid = 1'b0;
  logic        sel = 1'b0;

  logic        r0_ready, r0_clk, r0_load, r0_clrn, r0_pen, r0_busy, r0_done;
  logic        r1_ready, r1_clk, r1_load, r1_clrn, r1_pen, r1_busy, r1_done;
  logic [15:0] r0_par, r1_par;

  logic        o_ready, o_clk, o_load, o_clrn, o_pen, o_busy, o_done;
  logic [15:0] o_par;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  led_p2s_ctrl #(.DIV(4), .NBITS(16), .REFRESH(20)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid && !sel),
    .data_ready(r0_ready), .sr_clk(r0_clk), .sr_par(r0_par),
    .sr_load(r0_load), .led_clrn(r0_clrn), .led_pen(r0_pen),
    .busy(r0_busy), .frame_done(r0_done)
  );

  led_p2s_ctrl #(.DIV(1), .NBITS(16), .REFRESH(20)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(valid && sel),
    .data_ready(r1_ready), .sr_clk(r1_clk), .sr_par(r1_par),
    .sr_load(r1_load), .led_clrn(r1_clrn), .led_pen(r1_pen),
    .busy(r1_busy), .frame_done(r1_done)
  );

  assign o_ready = sel ? r1_ready : r0_ready;
  assign o_clk   = sel ? r1_clk   : r0_clk;
  assign o_load  = sel ? r1_load  : r0_load;
  assign o_clrn  = sel ? r1_clrn  : r0_clrn;
  assign o_pen   = sel ? r1_pen   : r0_pen;
  assign o_busy  = sel ? r1_busy  : r0_busy;
  assign o_done  = sel ? r1_done  : r0_done;
  assign o_par   = sel ? r1_par   : r0_par;

  typedef struct {
    logic        sel;
    logic [15:0] word;
    logic        noise;
    int          len;
    int          load_n;
    int          rises;
    int          pen_n;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int n, g, load_n, pen_n, rises;
    logic prev_clk, got;
    logic [15:0] exp_w;
    sel = v.sel;
    g = 0;
    while (!o_ready && g < 400) begin
      tick();
      g++;
    end
    check("ready_before", o_ready, 1);
    data_in = v.word;
    valid = 1'b1;
    exp_q.push_back(v.word);
    tick();
    valid = 1'b0;
    n = 0; load_n = 0; pen_n = 0; rises = 0;
    prev_clk = 1'b0; got = 1'b0;
    while (n < 1000) begin
      if (o_load) load_n++;
      if (o_pen) pen_n++;
      if (o_clk && !prev_clk && !o_load && !o_pen && o_busy) rises++;
      prev_clk = o_clk;
      if (v.noise && n >= 40 && n < 43) begin
        data_in = 16'hFFFF;
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      if (o_done) begin
        got = 1'b1;
        break;
      end
      tick();
      n++;
    end
    valid = 1'b0;
    check("done_seen", got, 1);
    check("frame_len", n, v.len);
    check("load_cycles", load_n, v.load_n);
    check("shift_rises", rises, v.rises);
    check("pen_cycles", pen_n, v.pen_n);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("sr_par", o_par, exp_w);
    check("ready_at_done", o_ready, 1);
    check("busy_at_done", o_busy, 0);
    if (v.noise) begin
      repeat (10) tick();
      check("no_extra_frame", o_busy, 0);
      check("par_kept", o_par, v.word);
    end
  endtask

  initial begin
    int n;
    logic pen_seen;
    vec_t v;

    vecs[0] = '{1'b0, 16'hA5C3, 1'b1, 144, 8, 16, 8};
    vecs[1] = '{1'b1, 16'hFFFF, 1'b0, 36, 2, 16, 2};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 144, 8, 16, 8};
    vecs[3] = '{1'b1, 16'h1234, 1'b0, 36, 2, 16, 2};
    vecs[4] = '{1'b0, 16'h3C3C, 1'b0, 144, 8, 16, 8};

    rst = 1'b1;
    valid = 1'b1;
    data_in = 16'h1234;
    tick();
    tick();
    check("rst_sr_clk", o_clk, 0);
    check("rst_load", o_load, 0);
    check("rst_par", o_par, 0);
    check("rst_pen", o_pen, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ready", o_ready, 0);
    check("rst_clrn", o_clrn, 0);
    rst = 1'b0;
    valid = 1'b0;
    tick();
    check("post_rst_ready", o_ready, 1);
    check("post_rst_clrn", o_clrn, 1);
    check("post_rst_busy", o_busy, 0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    sel = 1'b0;
    n = 0;
    while (!o_ready && n < 400) begin
      tick();
      n++;
    end
    data_in = 16'h5A5A;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n = 0;
    pen_seen = 1'b0;
    while (n < 70) begin
      if (o_pen) pen_seen = 1'b1;
      tick();
      n++;
    end
    check("mid_shift_busy", o_busy, 1);
    rst = 1'b1;
    tick();
    check("midrst_sr_clk", o_clk, 0);
    check("midrst_load", o_load, 0);
    check("midrst_par", o_par, 0);
    check("midrst_pen", o_pen, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_clrn", o_clrn, 0);
    check("midrst_pen_never", pen_seen, 0);
    rst = 1'b0;
    tick();
    check("midrst_ready_back", o_ready, 1);
    run_frame(vecs[4]);

`ifdef LED_P2S_AUTOREFRESH_EN
    v = '{1'b0, 16'h0001, 1'b0, 144, 8, 16, 8};
    run_frame(v);
    n = 0;
    while (!o_busy && n < 100) begin
      tick();
      n++;
    end
    check("refresh_delay", n, 20);
    check("refresh_par", o_par, 16'h0001);
    n = 0;
    while (!o_done && n < 400) begin
      tick();
      n++;
    end
    check("refresh_done", o_done, 1);
    n = 0;
    while (n < 19) begin
      tick();
      n++;
    end
    check("refresh_idle", o_busy, 0);
    data_in = 16'h8000;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("hs_wins_busy", o_busy, 1);
    check("hs_wins_par", o_par, 16'h8000);
    n = 0;
    while (!o_done && n < 400) begin
      tick();
      n++;
    end
    check("hs_wins_done", o_done, 1);
`else
    v = vecs[0];
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_p2s_ctrl.md
# led_p2s_ctrl

Sequencer that drives the 16-bit parallel-to-serial LED shift stage and the external LED driver chain. It accepts a 16-bit LED word over a valid/ready handshake and generates a divided shift clock for the stage. It also generates the stage's parallel data and load level, plus the chain's clear and latch strobes. It sits directly upstream of the shift stage, whose serial output feeds the LED chain data pin.

## Interface
- DIV, 4: clk cycles per sr_clk half-period; legal range ≥1.
- NBITS, 16: bits shifted per frame; must match the shift stage's parallel width.
- REFRESH, 50000: idle clk cycles before an automatic re-send; used only when auto-refresh is compiled in.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  16  LED word to display.
- data_valid  in  1  data_in valid.
- data_ready  out  1  high only in IDLE; a word is accepted when data_valid && data_ready at a clk edge.
- sr_clk  out  1  shift clock to the stage and the LED chain.
- sr_par  out  16  parallel word to the stage; holds the last accepted word.
- sr_load  out  1  load level to the stage; the stage loads on this signal's 0→1 transition.
- led_clrn  out  1  LED chain clear, active-low.
- led_pen  out  1  LED chain output latch strobe, active-high.
- busy  out  1  high in LOAD, SHIFT and LATCH.
- frame_done  out  1  one-clk pulse when a frame completes.

## Operation
- States: IDLE, LOAD, SHIFT, LATCH.
- Phase generator:
  - In any non-IDLE state, div_cnt counts 0..DIV-1.
  - At terminal count, sr_clk toggles.
  - The 0→1 toggle is a rise tick; the 1→0 toggle is a fall tick.
  - On leaving IDLE, div_cnt and sr_clk are cleared.
- IDLE→LOAD on handshake: data_in is captured into sr_par, and sr_load is set to 1 on the same edge.
- LOAD: sr_load stays high through the first rise tick, where the stage loads. On the next fall tick, sr_load goes to 0, bit_cnt is cleared, and the state moves to SHIFT.
- SHIFT: the stage shifts on each rise tick. bit_cnt increments on each fall tick. On the fall tick where bit_cnt reaches NBITS-1, the state moves to LATCH.
- LATCH: led_pen is high for one full sr_clk period (2·DIV clk cycles). On the closing fall tick, led_pen goes to 0, the state moves to IDLE, and frame_done pulses for one clk.
- All control outputs change only on fall ticks, giving setup time of DIV clk cycles before each stage rise edge.
- data_valid while busy is ignored; no word is queued.
- A reset mid-frame abandons the frame. led_pen is never asserted for a partial frame.

## Timing
- Reset values (first clk edge with rst=1):
  - sr_clk=0, sr_load=0, sr_par=0, led_pen=0, busy=0, frame_done=0, data_ready=0.
  - led_clrn=0 while rst=1; 1 from the first edge after rst drops.
- data_ready rises on the first edge after rst drops.
- Handshake edge to frame_done pulse: (NBITS+2)·2·DIV clk cycles. Defaults: 144 cycles.
- data_ready is high on the cycle after frame_done, so back-to-back frames have a 1-clk IDLE gap.
- sr_clk is held at 0 in IDLE.

## Configuration
- LED_P2S_AUTOREFRESH_EN defined:
  - An idle timer counts clk cycles in IDLE.
  - At REFRESH-1, it starts a frame using the held sr_par, without a handshake.
  - A handshake in the same cycle wins and loads the new word.
  - The timer clears on leaving IDLE and on reset.
  - Before the first accepted word, the refresh frame sends 0.
- Not defined: frames start only on a handshake. No timer logic is present.

## Structure
- Package led_p2s_pkg holds the state enum, the 16-bit word width constant and the default DIV/REFRESH constants.
- Sub-module led_p2s_clkgen holds div_cnt and sr_clk and outputs rise_tick and fall_tick strobes, with enable and clear inputs.
- The FSM, bit_cnt and refresh timer stay in the top module.

## Test plan
- Reset with data_valid=1: all outputs at reset values, led_clrn=0; one cycle after rst drops, data_ready=1 and led_clrn=1.
- Send 16'hA5C3 with DIV=4: sr_par=A5C3; sr_load high for exactly 8 clk around the first sr_clk rise; 16 further rises in SHIFT; led_pen high for 8 clk; frame_done at cycle 144.
- data_valid pulses during SHIFT with 16'hFFFF: ignored, sr_par stays A5C3, no extra frame.
- Assert rst during SHIFT at bit 7: outputs return to reset values next edge; led_pen never rises; the next word frames normally.
- With LED_P2S_AUTOREFRESH_EN and REFRESH=20: after a 16'h0001 frame, a new frame starts 20 idle cycles later with sr_par=0001. If a handshake with 16'h8000 is given on that same cycle, 8000 is loaded instead.
- DIV=1: sr_clk period is 2 clk; frame length is 36 clk.
